trig_level_ctrl: RTL

Front-panel trigger-level controller for the scope. It synchronises and debounces the up/down push buttons and turns presses and holds into a saturating 12-bit trigger level, TRIG. TRIG is consumed by the capture FIFO (trigger compare) and the voltage-scale stage (red trigger-line overlay). It sits directly upstream of both and runs on the 50 MHz system clock.

---
 rtl/trig_level_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/trig_level_ctrl.sv
// Front-panel trigger-level controller: sync, debounce, step/repeat/recall.
// Define TRIG_ACCEL_EN to switch to 4*STEP after 8 consecutive repeat steps.
module trig_level_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int STEP            = 16,
    parameter int TRIG_INIT       = 2048,
    parameter int TRIG_MIN        = 0,
    parameter int TRIG_MAX        = 4095
) (
    input  logic        CLK,
    input  logic        RSTB,
    input  logic        button_u,
    input  logic        button_d,
    output logic [11:0] TRIG,
    output logic        trig_changed,
    output logic        at_limit
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RPT_M = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W = (RPT_M > 1) ? $clog2(RPT_M) : 1;

    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RR_LAST = RPT_W'(REPEAT_RATE - 1);

    localparam logic [12:0] STEP13 = 13'(STEP);
    localparam logic [12:0] MIN13  = 13'(TRIG_MIN);
    localparam logic [12:0] MAX13  = 13'(TRIG_MAX);
    localparam logic [11:0] INIT12 = 12'(TRIG_INIT);
    localparam logic        LIM_RST = (TRIG_INIT == TRIG_MIN) || (TRIG_INIT == TRIG_MAX);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT,
        RECALL
    } state_e;

    // Index 1 = up, index 0 = down
    logic [1:0]      s1_q, s2_q;
    logic [1:0]      press;
    logic [1:0]      db_q, db_d;
    logic [DB_W-1:0] cnt_q [2];
    logic [DB_W-1:0] cnt_d [2];

    state_e           state_q, state_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             dir_q, dir_d;
    logic             do_step, step_up, do_recall;
    logic             act_btn, oth_btn;

    logic [11:0] trig_q, trig_d;
    logic        chg_q, lim_q;
    logic [12:0] step_sz, up_sum, dn_diff;
    logic [11:0] up_val, dn_val;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            s1_q <= 2'b11;
            s2_q <= 2'b11;
        end else begin
            s1_q <= {button_u, button_d};
            s2_q <= s1_q;
        end
    end

    assign press = ~s2_q;

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (press[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) db_d[i] = press[i];
                else cnt_d[i] = cnt_q[i] + DB_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            db_q <= 2'b00;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            db_q <= db_d;
            for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign act_btn = dir_q ? db_q[1] : db_q[0];
    assign oth_btn = dir_q ? db_q[0] : db_q[1];

`ifdef TRIG_ACCEL_EN
    logic [3:0] acc_q, acc_d;
    logic       rpt_step;
`endif

    always_comb begin
        state_d   = state_q;
        rpt_d     = rpt_q;
        dir_d     = dir_q;
        do_step   = 1'b0;
        step_up   = dir_q;
        do_recall = 1'b0;
`ifdef TRIG_ACCEL_EN
        rpt_step  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                rpt_d = '0;
                if (db_q[1] && db_q[0]) begin
                    state_d   = RECALL;
                    do_recall = 1'b1;
                end else if (db_q[1] || db_q[0]) begin
                    state_d = DELAY;
                    dir_d   = db_q[1];
                    step_up = db_q[1];
                    do_step = 1'b1;
                end
            end
            DELAY: begin
                if (oth_btn) begin
                    state_d   = RECALL;
                    do_recall = 1'b1;
                    rpt_d     = '0;
                end else if (!act_btn) begin
                    state_d = IDLE;
                    rpt_d   = '0;
                end else if (rpt_q == RD_LAST) begin
                    state_d = REPEAT;
                    rpt_d   = '0;
                end else begin
                    rpt_d = rpt_q + RPT_W'(1);
                end
            end
            REPEAT: begin
                if (oth_btn) begin
                    state_d   = RECALL;
                    do_recall = 1'b1;
                    rpt_d     = '0;
                end else if (!act_btn) begin
                    state_d = IDLE;
                    rpt_d   = '0;
                end else if (rpt_q == RR_LAST) begin
                    do_step = 1'b1;
                    rpt_d   = '0;
`ifdef TRIG_ACCEL_EN
                    rpt_step = 1'b1;
`endif
                end else begin
                    rpt_d = rpt_q + RPT_W'(1);
                end
            end
            RECALL: begin
                rpt_d = '0;
                if (!db_q[1] && !db_q[0]) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                rpt_d   = '0;
            end
        endcase
    end

`ifdef TRIG_ACCEL_EN
    always_comb begin
        acc_d = acc_q;
        if (state_d == IDLE || state_d == RECALL) acc_d = '0;
        else if (rpt_step && acc_q != 4'd8) acc_d = acc_q + 4'd1;
        step_sz = (acc_q == 4'd8) ? 13'(4 * STEP) : STEP13;
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) acc_q <= '0;
        else acc_q <= acc_d;
    end
`else
    assign step_sz = STEP13;
`endif

    // 13-bit arithmetic keeps both overflow and underflow visible before clamping
    assign up_sum  = {1'b0, trig_q} + step_sz;
    assign dn_diff = {1'b0, trig_q} - step_sz;
    assign up_val  = (up_sum > MAX13) ? MAX13[11:0] : up_sum[11:0];
    assign dn_val  = ({1'b0, trig_q} < MIN13 + step_sz) ? MIN13[11:0] : dn_diff[11:0];

    always_comb begin
        trig_d = trig_q;
        if (do_recall) trig_d = INIT12;
        else if (do_step) trig_d = step_up ? up_val : dn_val;
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= IDLE;
            rpt_q   <= '0;
            dir_q   <= 1'b0;
            trig_q  <= INIT12;
            chg_q   <= 1'b0;
            lim_q   <= LIM_RST;
        end else begin
            state_q <= state_d;
            rpt_q   <= rpt_d;
            dir_q   <= dir_d;
            trig_q  <= trig_d;
            chg_q   <= (trig_d != trig_q);
            lim_q   <= ({1'b0, trig_d} == MIN13) || ({1'b0, trig_d} == MAX13);
        end
    end

    assign TRIG         = trig_q;
    assign trig_changed = chg_q;
    assign at_limit     = lim_q;

endmodule
